reduce_tree_pipe: RTL and testbench

- Parametrised, pipelined N-way bitwise reduction unit; generalises the fixed 8-input OR tree to WIDTH inputs, selectable OR/AND/XOR/NOR, and multi-beat packets.
- Per beat: balanced 2-input tree, one register per tree level; results of all beats of a packet fold into a running accumulator, and the unit emits one result bit per packet on the last beat.
- Valid/ready on both sides; sits between ALU-side status logic and flag/interrupt consumers.

---
 rtl/reduce_tree_pipe_if.sv | 36 +++
 rtl/reduce_tree_pipe.sv | 164 ++++++++++++++++
 tb/tb_reduce_tree_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reduce_tree_pipe_if.sv
// Beat stream in, one-bit-per-packet result stream out, for reduce_tree_pipe.
// With REDUCE_FIRST_EN defined the result side also carries out_hit/out_first.
interface reduce_tree_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic             out_result;
  logic [CNT_W-1:0] out_beats;
  logic             out_valid;
  logic             out_ready;
`ifdef REDUCE_FIRST_EN
  logic             out_hit;
  logic [CNT_W-1:0] out_first;
`endif

  modport master (
    output in_data, in_op, in_last, in_valid, out_ready,
`ifdef REDUCE_FIRST_EN
    input  out_hit, out_first,
`endif
    input  in_ready, out_result, out_beats, out_valid
  );

  modport slave (
    input  in_data, in_op, in_last, in_valid, out_ready,
`ifdef REDUCE_FIRST_EN
    output out_hit, out_first,
`endif
    output in_ready, out_result, out_beats, out_valid
  );
endinterface

// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-input bitwise reduction (OR/AND/XOR/NOR) folded over multi-beat packets.
// Define REDUCE_FIRST_EN to add out_hit/out_first (first beat with any bit set).
module reduce_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               reset,
  reduce_tree_pipe_if.slave bus
);
  localparam int L  = $clog2(WIDTH);
  localparam int TW = 2 * WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {FIRST, MID} acc_state_t;

  function automatic logic red2(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  logic stall, adv, take;
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign adv          = ~stall;
  assign take         = bus.in_valid & adv;
  assign bus.in_ready = adv;

  // The op is latched from the first beat so later beats of the packet reduce with it.
  logic       in_first;
  logic [1:0] pkt_op, beat_op;
  assign beat_op = in_first ? bus.in_op : pkt_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_first <= 1'b1;
      pkt_op   <= 2'b00;
    end else if (take) begin
      in_first <= bus.in_last;
      if (in_first) pkt_op <= bus.in_op;
    end
  end

  // All tree levels packed into one vector: level j starts at 2*WIDTH - (2*WIDTH >> j).
  logic [TW-1:0]   tree, tree_nxt;
  logic [L:0]      vld, lst, fst;
  logic [L:0][1:0] opq;

  assign tree_nxt[WIDTH-1:0] = bus.in_data;

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int SRC = 2 * WIDTH - ((2 * WIDTH) >> (j - 1));
    localparam int DST = 2 * WIDTH - ((2 * WIDTH) >> j);
    for (genvar b = 0; b < (WIDTH >> j); b++) begin : g_node
      assign tree_nxt[DST+b] = red2(opq[j-1], tree[SRC+2*b], tree[SRC+2*b+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tree <= '0;
      vld  <= '0;
      lst  <= '0;
      fst  <= '0;
      opq  <= '0;
    end else if (adv) begin
      tree <= tree_nxt;
      vld  <= {vld[L-1:0], take};
      lst  <= {lst[L-1:0], bus.in_last};
      fst  <= {fst[L-1:0], in_first};
      opq  <= {opq[L-1:0], beat_op};
    end
  end

  acc_state_t       state, state_nxt;
  logic             acc, acc_nxt, beat, first_beat, emit, res_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign beat = tree[TW-1];

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    emit       = 1'b0;
    first_beat = (state == FIRST) | fst[L];
    if (vld[L]) begin
      if (first_beat) begin
        acc_nxt = beat;
        cnt_nxt = CNT_ONE;
      end else begin
        acc_nxt = red2(opq[L], acc, beat);
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      end
      emit      = lst[L];
      state_nxt = lst[L] ? FIRST : MID;
    end
    // NOR is an OR tree with a single inversion at emit.
    res_nxt = acc_nxt ^ (opq[L] == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FIRST;
      acc            <= 1'b0;
      cnt            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= 1'b0;
      bus.out_beats  <= '0;
    end else if (adv) begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      cnt           <= cnt_nxt;
      bus.out_valid <= emit;
      if (emit) begin
        bus.out_result <= res_nxt;
        bus.out_beats  <= cnt_nxt;
      end
    end
  end

`ifdef REDUCE_FIRST_EN
  logic [L:0]       anyq;
  logic             hit, hit_nxt;
  logic [CNT_W-1:0] fidx, fidx_nxt;

  // cnt before this beat's increment is its saturated 0-based index within the packet.
  always_comb begin
    hit_nxt  = hit;
    fidx_nxt = fidx;
    if (vld[L]) begin
      if (first_beat) begin
        hit_nxt  = anyq[L];
        fidx_nxt = '0;
      end else if (!hit && anyq[L]) begin
        hit_nxt  = 1'b1;
        fidx_nxt = cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anyq          <= '0;
      hit           <= 1'b0;
      fidx          <= '0;
      bus.out_hit   <= 1'b0;
      bus.out_first <= '0;
    end else if (adv) begin
      anyq <= {anyq[L-1:0], |bus.in_data};
      hit  <= hit_nxt;
      fidx <= fidx_nxt;
      if (emit) begin
        bus.out_hit   <= hit_nxt;
        bus.out_first <= fidx_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed-vector bench for reduce_tree_pipe (WIDTH=8, CNT_W=4); results collected by a monitor.
// Also checks out_hit/out_first when built with REDUCE_FIRST_EN.
module tb_reduce_tree_pipe;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   last_acc_cyc = 0;

  logic got_res[$];
  int   got_beats[$];
  int   got_cyc[$];
  logic exp_res[$];
  int   exp_beats[$];
`ifdef REDUCE_FIRST_EN
  logic got_hit[$];
  int   got_first[$];
`endif

  always #5 clk = ~clk;

  reduce_tree_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  reduce_tree_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so everything is stable at negedge for the coming edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      got_res.push_back(bus.out_result);
      got_beats.push_back(int'(bus.out_beats));
      got_cyc.push_back(cyc);
`ifdef REDUCE_FIRST_EN
      got_hit.push_back(bus.out_hit);
      got_first.push_back(int'(bus.out_first));
`endif
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [1:0] op, input logic last);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_op    = op;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("in_ready_timeout", 32'(n), 32'd0);
    last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic addExpected(input logic r, input int beats);
    exp_res.push_back(r);
    exp_beats.push_back(beats);
  endtask

  task automatic clearAll();
    got_res.delete();
    got_beats.delete();
    got_cyc.delete();
    exp_res.delete();
    exp_beats.delete();
`ifdef REDUCE_FIRST_EN
    got_hit.delete();
    got_first.delete();
`endif
  endtask

  task automatic compareAll(input string tag);
    int k;
    k = 0;
    while (got_res.size() < exp_res.size() && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    checkOutput({tag, "_count"}, 32'(got_res.size()), 32'(exp_res.size()));
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      checkOutput($sformatf("%s_res%0d", tag, i), 32'(got_res[i]), 32'(exp_res[i]));
      checkOutput($sformatf("%s_beats%0d", tag, i), 32'(got_beats[i]), 32'(exp_beats[i]));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, summary not reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t_acc;
    bus.in_data   = '0;
    bus.in_op     = 2'b00;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_result", 32'(bus.out_result), 32'd0);
    checkOutput("rst_out_beats", 32'(bus.out_beats), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single-beat OR packets back to back: latency and one result per cycle.
    clearAll();
    addExpected(1'b0, 1);
    addExpected(1'b1, 1);
    addExpected(1'b1, 1);
    applyStimulus(8'h00, 2'b00, 1'b1);
    t_acc = last_acc_cyc;
    applyStimulus(8'h10, 2'b00, 1'b1);
    applyStimulus(8'hFF, 2'b00, 1'b1);
    compareAll("single");
    if (got_cyc.size() >= 3) begin
      checkOutput("single_latency", 32'(got_cyc[0] - t_acc), 32'd5);
      checkOutput("single_spacing", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
    end

    // Op sweep.
    clearAll();
    addExpected(1'b0, 1);
    addExpected(1'b1, 1);
    addExpected(1'b0, 1);
    addExpected(1'b1, 1);
    applyStimulus(8'hFE, 2'b01, 1'b1);
    applyStimulus(8'hFE, 2'b10, 1'b1);
    applyStimulus(8'hFE, 2'b11, 1'b1);
    applyStimulus(8'h00, 2'b11, 1'b1);
    compareAll("opsweep");
`ifdef REDUCE_FIRST_EN
    if (got_hit.size() >= 4) checkOutput("opsweep_hit_zero", 32'(got_hit[3]), 32'd0);
`endif

    // Op latched from the first beat; in_op on later beats ignored.
    clearAll();
    addExpected(1'b0, 3);
    applyStimulus(8'hFF, 2'b01, 1'b0);
    applyStimulus(8'hFF, 2'b00, 1'b0);
    applyStimulus(8'h7F, 2'b00, 1'b1);
    compareAll("andpkt");

    // Consumer stall while XOR packets stream in.
    clearAll();
    addExpected(1'b1, 1);
    addExpected(1'b0, 1);
    addExpected(1'b1, 1);
    addExpected(1'b0, 1);
    addExpected(1'b1, 1);
    bus.out_ready = 1'b0;
    fork
      begin : g_send
        applyStimulus(8'h01, 2'b10, 1'b1);
        applyStimulus(8'h03, 2'b10, 1'b1);
        applyStimulus(8'h07, 2'b10, 1'b1);
        applyStimulus(8'h0F, 2'b10, 1'b1);
        applyStimulus(8'h1F, 2'b10, 1'b1);
      end
      begin : g_stall
        int k;
        k = 0;
        while (!bus.out_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("stall_held0", 32'(bus.out_result), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("stall_held1", 32'(bus.out_result), 32'd1);
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    compareAll("stall");

    // 20-beat OR packet, only beat 17 non-zero: count saturates, result exact.
    clearAll();
    addExpected(1'b1, 15);
    for (int i = 0; i < 20; i++)
      applyStimulus((i == 17) ? 8'h01 : 8'h00, 2'b00, (i == 19) ? 1'b1 : 1'b0);
    compareAll("long");
`ifdef REDUCE_FIRST_EN
    if (got_hit.size() >= 1) begin
      checkOutput("long_hit", 32'(got_hit[0]), 32'd1);
      checkOutput("long_first", 32'(got_first[0]), 32'd15);
    end
`endif

    // Two-beat XOR packet folds across beats: 1 ^ 0.
    clearAll();
    addExpected(1'b1, 2);
    applyStimulus(8'h01, 2'b10, 1'b0);
    applyStimulus(8'h03, 2'b01, 1'b1);
    compareAll("xorpkt");
`ifdef REDUCE_FIRST_EN
    if (got_first.size() >= 1) checkOutput("xorpkt_first", 32'(got_first[0]), 32'd0);
`endif

    // Reset with a pending result and a partial packet in flight.
    clearAll();
    bus.out_ready = 1'b0;
    applyStimulus(8'h01, 2'b00, 1'b1);
    applyStimulus(8'hFF, 2'b00, 1'b0);
    applyStimulus(8'hFF, 2'b00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("prerst_pending", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    addExpected(1'b0, 1);
    applyStimulus(8'h01, 2'b01, 1'b1);
    compareAll("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
